// File: rtl/acc_src_sel_pipe.sv
// Accumulator-source selector: N_SRC-way word mux, registered behind a
// valid/ready handshake with a 2-entry skid buffer and a sticky illegal-select flag.
module acc_src_sel_pipe #(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned N_SRC  = 3,
    parameter int unsigned SEL_W  = 2,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_SRC*DATA_W-1:0] src_data_i,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [DATA_W-1:0]       out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [SEL_W-1:0]        out_sel_o,
    output logic                    sel_err_o,
    input  logic                    err_clr_i
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [SEL_W-1:0]    main_sel_q, main_sel_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [SEL_W-1:0]    skid_sel_q, skid_sel_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                sel_err_q, sel_err_d;

    logic [DATA_W-1:0]   sel_word;
    logic                sel_legal;
    logic                accept;
    logic                consume;
    logic                push;

    // Source mux; out-of-range codes never index past the flattened bus
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < int'(N_SRC); k++) begin
            if (sel_i == SEL_W'(k)) begin
                sel_word = src_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_legal = ({1'b0, sel_i} < (SEL_W+1)'(N_SRC));
    assign accept    = in_valid_i & in_ready_q;
    assign consume   = out_valid_q & out_ready_i;
    assign push      = accept & sel_legal;

    // Next-state: occupancy FSM, data movement, and registered handshake flags
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        sel_err_d   = sel_err_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    main_data_d = sel_word;
                    main_sel_d  = sel_i;
                    state_d     = ST_FULL;
                end
            end
            ST_FULL: begin
                if (push && consume) begin
                    main_data_d = sel_word;
                    main_sel_d  = sel_i;
                end else if (push) begin
                    skid_data_d = sel_word;
                    skid_sel_d  = sel_i;
                    state_d     = ST_SKID;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (consume) begin
                    main_data_d = skid_data_q;
                    main_sel_d  = skid_sel_q;
                    state_d     = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Set has priority over clear
        if (accept && !sel_legal) begin
            sel_err_d = 1'b1;
        end else if (err_clr_i) begin
            sel_err_d = 1'b0;
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_SKID);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            main_data_q <= RST_VAL;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_data_o  = main_data_q;
    assign out_sel_o   = main_sel_q;
    assign out_valid_o = out_valid_q;
    assign in_ready_o  = in_ready_q;
    assign sel_err_o   = sel_err_q;

endmodule

// File: tb/tb_acc_src_sel_pipe.sv
// Bench for acc_src_sel_pipe: directed steps on the default build plus random
// traffic on both a default and a 16-bit/4-source build, against a queue model.
module tb_acc_src_sel_pipe;

    logic clk;
    logic rst;

    logic [32:0] src_a;
    logic [1:0]  sel_a;
    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, sel_err_a, clr_a;
    logic [10:0] out_data_a;
    logic [1:0]  out_sel_a;

    logic [63:0] src_b;
    logic [1:0]  sel_b;
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, sel_err_b, clr_b;
    logic [15:0] out_data_b;
    logic [1:0]  out_sel_b;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  s;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    bit   err_a;
    bit   err_b;

    int checks = 0;
    int errors = 0;

    acc_src_sel_pipe #(.DATA_W(11), .N_SRC(3), .SEL_W(2), .RST_VAL(11'h000)) dut_a (
        .clk_i(clk), .rst_i(rst), .src_data_i(src_a), .sel_i(sel_a),
        .in_valid_i(in_valid_a), .in_ready_o(in_ready_a), .out_data_o(out_data_a),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready_a), .out_sel_o(out_sel_a),
        .sel_err_o(sel_err_a), .err_clr_i(clr_a)
    );

    acc_src_sel_pipe #(.DATA_W(16), .N_SRC(4), .SEL_W(2), .RST_VAL(16'h0000)) dut_b (
        .clk_i(clk), .rst_i(rst), .src_data_i(src_b), .sel_i(sel_b),
        .in_valid_i(in_valid_b), .in_ready_o(in_ready_b), .out_data_o(out_data_b),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready_b), .out_sel_o(out_sel_b),
        .sel_err_o(sel_err_b), .err_clr_i(clr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_valid", 32'(out_valid_a), 32'(qa.size() > 0));
        chk("a_ready", 32'(in_ready_a), 32'(qa.size() < 2));
        chk("a_err", 32'(sel_err_a), 32'(err_a));
        if (qa.size() > 0) begin
            chk("a_data", 32'(out_data_a), 32'(qa[0].d));
            chk("a_sel", 32'(out_sel_a), 32'(qa[0].s));
        end
        chk("b_valid", 32'(out_valid_b), 32'(qb.size() > 0));
        chk("b_ready", 32'(in_ready_b), 32'(qb.size() < 2));
        chk("b_err", 32'(sel_err_b), 32'(err_b));
        if (qb.size() > 0) begin
            chk("b_data", 32'(out_data_b), 32'(qb[0].d));
            chk("b_sel", 32'(out_sel_b), 32'(qb[0].s));
        end
    endtask

    // One clock: the model sees the same inputs the DUTs sample at the edge
    task automatic tick();
        bit   acc_a, leg_a, con_a, acc_b, con_b;
        ent_t ea, eb, tmp;
        acc_a = in_valid_a && (qa.size() < 2);
        leg_a = (int'(sel_a) < 3);
        con_a = out_ready_a && (qa.size() > 0);
        acc_b = in_valid_b && (qb.size() < 2);
        con_b = out_ready_b && (qb.size() > 0);
        ea.s = sel_a;
        ea.d = leg_a ? 16'(src_a[int'(sel_a)*11 +: 11]) : 16'h0;
        eb.s = sel_b;
        eb.d = src_b[int'(sel_b)*16 +: 16];
        @(posedge clk);
        if (con_a) tmp = qa.pop_front();
        if (acc_a && leg_a) qa.push_back(ea);
        if (acc_a && !leg_a) err_a = 1'b1;
        else if (clr_a) err_a = 1'b0;
        if (con_b) tmp = qb.pop_front();
        if (acc_b) qb.push_back(eb);
        if (clr_b) err_b = 1'b0;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        src_a = {11'h055, 11'h3FF, 11'h12A};
        sel_a = 2'd0; in_valid_a = 1'b0; out_ready_a = 1'b1; clr_a = 1'b0;
        src_b = '0;
        sel_b = 2'd0; in_valid_b = 1'b0; out_ready_b = 1'b1; clr_b = 1'b0;
        err_a = 1'b0; err_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data", 32'(out_data_a), 32'h0);
        chk("rst_sel", 32'(out_sel_a), 32'h0);
        chk("rst_valid", 32'(out_valid_a), 32'h0);
        chk("rst_ready", 32'(in_ready_a), 32'h1);
        chk("rst_err", 32'(sel_err_a), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_all();

        // Pass-through, one word per cycle
        in_valid_a = 1'b1; sel_a = 2'd0; tick();
        chk("pass0_data", 32'(out_data_a), 32'h12A);
        sel_a = 2'd1; tick();
        chk("pass1_data", 32'(out_data_a), 32'h3FF);
        chk("pass1_valid", 32'(out_valid_a), 32'h1);
        sel_a = 2'd2; tick();
        chk("pass2_data", 32'(out_data_a), 32'h055);
        chk("pass2_sel", 32'(out_sel_a), 32'h2);
        in_valid_a = 1'b0; tick();
        chk("pass_drain", 32'(out_valid_a), 32'h0);

        // Back-pressure into the skid register
        out_ready_a = 1'b0; in_valid_a = 1'b1; sel_a = 2'd1; tick();
        sel_a = 2'd2; tick();
        chk("bp_ready", 32'(in_ready_a), 32'h0);
        chk("bp_hold", 32'(out_data_a), 32'h3FF);
        in_valid_a = 1'b0; tick();
        chk("bp_hold2", 32'(out_data_a), 32'h3FF);
        out_ready_a = 1'b1; tick();
        chk("bp_next", 32'(out_data_a), 32'h055);
        chk("bp_ready_back", 32'(in_ready_a), 32'h1);
        tick();
        chk("bp_empty", 32'(out_valid_a), 32'h0);

        // Illegal select drop and sticky flag
        in_valid_a = 1'b1; sel_a = 2'd3; tick();
        chk("ill_valid", 32'(out_valid_a), 32'h0);
        chk("ill_err", 32'(sel_err_a), 32'h1);
        sel_a = 2'd0; tick();
        chk("ill_sticky", 32'(sel_err_a), 32'h1);
        chk("ill_legal_data", 32'(out_data_a), 32'h12A);
        in_valid_a = 1'b0; clr_a = 1'b1; tick();
        chk("ill_clr", 32'(sel_err_a), 32'h0);
        clr_a = 1'b0;

        // Set wins over clear
        in_valid_a = 1'b1; sel_a = 2'd3; tick();
        clr_a = 1'b1; tick();
        chk("collide_err", 32'(sel_err_a), 32'h1);
        in_valid_a = 1'b0; tick();
        chk("collide_clr", 32'(sel_err_a), 32'h0);
        clr_a = 1'b0;

        // Async reset while holding two words
        out_ready_a = 1'b0; in_valid_a = 1'b1; sel_a = 2'd0; tick();
        sel_a = 2'd1; tick();
        chk("pre_rst_ready", 32'(in_ready_a), 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid_a), 32'h0);
        chk("arst_data", 32'(out_data_a), 32'h0);
        chk("arst_ready", 32'(in_ready_a), 32'h1);
        qa.delete(); qb.delete(); err_a = 1'b0; err_b = 1'b0;
        in_valid_a = 1'b0; out_ready_a = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("arst_no_stale", 32'(out_valid_a), 32'h0);

        // Random traffic on both builds
        for (int i = 0; i < 1000; i++) begin
            src_a = 33'({$urandom(), $urandom()});
            sel_a = 2'($urandom_range(0, 3));
            in_valid_a = 1'($urandom_range(0, 1));
            out_ready_a = 1'($urandom_range(0, 1));
            clr_a = ($urandom_range(0, 7) == 0);
            src_b = {$urandom(), $urandom()};
            sel_b = 2'($urandom_range(0, 3));
            in_valid_b = ($urandom_range(0, 3) != 0);
            out_ready_b = ($urandom_range(0, 2) != 0);
            clr_b = ($urandom_range(0, 15) == 0);
            tick();
        end
        in_valid_a = 1'b0; in_valid_b = 1'b0; out_ready_a = 1'b1; out_ready_b = 1'b1;
        repeat (3) tick();
        chk("final_b_err", 32'(sel_err_b), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_src_sel_pipe.md
Name: acc_src_sel_pipe

Overview:
- Parametrised successor to the accumulator-source selector of the BIP datapath.
- Selects one of N_SRC source words (memory data, sign-extended immediate, ULA result, and future sources) and registers the result.
- Provides a valid/ready handshake with a 2-entry skid buffer, so the accumulator-load path can be back-pressured without dropping operands.
- Illegal select codes are detected and flagged instead of producing a latched or undefined output.

Parameters:
- DATA_W, 11, width of each source word and of the output.
- N_SRC, 3, number of source channels (2..2**SEL_W).
- SEL_W, 2, width of the select code.
- RST_VAL, 0, value driven on out_data_o after reset.

Ports:
- clk_i  input  1  rising-edge clock.
- rst_i  input  1  asynchronous, active-high reset.
- src_data_i  input  N_SRC*DATA_W  flattened sources; channel k occupies bits [k*DATA_W +: DATA_W].
- sel_i  input  SEL_W  channel select, sampled with the input handshake.
- in_valid_i  input  1  upstream presents sel_i/src_data_i.
- in_ready_o  output  1  block accepts a transfer this cycle.
- out_data_o  output  DATA_W  selected, registered word.
- out_valid_o  output  1  out_data_o holds an unconsumed word.
- out_ready_i  input  1  downstream consumes the word when out_valid_o is high.
- out_sel_o  output  SEL_W  select code that produced out_data_o.
- sel_err_o  output  1  sticky illegal-select flag.
- err_clr_i  input  1  clears sel_err_o.

Behaviour:
- Reset (asynchronous, rst_i=1) forces:
  - out_data_o=RST_VAL, out_sel_o=0, out_valid_o=0, sel_err_o=0, in_ready_o=1.
  - Skid register empty.
  - Reset mid-transfer discards all held words.
- Accept condition: in_valid_i & in_ready_o. Consume condition: out_valid_o & out_ready_i.
- Legal select means sel_i < N_SRC. An accepted legal word carries src_data_i[sel_i*DATA_W +: DATA_W] and sel_i.
- An accepted illegal select (sel_i >= N_SRC):
  - The word is dropped; nothing enters the pipeline.
  - sel_err_o goes to 1 on the next edge and stays set until err_clr_i.
  - If an illegal accept and err_clr_i occur in the same cycle, set wins.
- State machine, on the count of held words:
  - EMPTY (out_valid_o=0, in_ready_o=1): a legal accept loads the main register -> FULL. Latency is 1 cycle from accept to out_valid_o.
  - FULL (out_valid_o=1, in_ready_o=1):
    - Consume with no accept -> EMPTY.
    - Accept with consume -> main register reloads, stays FULL (full throughput, one word per cycle).
    - Accept with no consume -> word goes to the skid register -> SKID.
  - SKID (out_valid_o=1, in_ready_o=0): a consume moves skid to main -> FULL. No accept is possible.
- in_ready_o is driven from a register (no combinational path from out_ready_i).
- out_data_o and out_sel_o hold stable while out_valid_o=1 and out_ready_i=0.
- Ordering is strictly FIFO; no word is duplicated or lost except illegal-select drops.
- With N_SRC == 2**SEL_W there is no illegal code, and sel_err_o stays 0.
- Source and select inputs are ignored when no accept occurs.

Test Plan:
- Reset then pass-through:
  - Stimulus: release rst_i; src0=0x12A, src1=0x3FF, src2=0x055; with out_ready_i=1, accept sel=0,1,2 in consecutive cycles.
  - Required: out_data_o = 0x12A, 0x3FF, 0x055 on cycles 1, 2, 3; out_sel_o = 0, 1, 2; out_valid_o stays high for the 3 cycles.
- Back-pressure:
  - Stimulus: out_ready_i=0; accept sel=1 (0x3FF), then sel=2 (0x055).
  - Required: in_ready_o=0 from the next cycle; out_data_o holds 0x3FF. After out_ready_i=1, 0x3FF then 0x055 are delivered, and in_ready_o returns to 1.
- Illegal select:
  - Stimulus: accept sel=3 with N_SRC=3.
  - Required: out_valid_o remains 0, sel_err_o=1 on the next edge, and it stays 1 through a following legal transfer. Pulsing err_clr_i clears it.
- Set/clear collision:
  - Stimulus: sel_err_o=1; in the same cycle assert err_clr_i and accept sel=3.
  - Required: sel_err_o stays 1.
- Async reset mid-operation:
  - Stimulus: in SKID state, assert rst_i between clock edges.
  - Required: out_valid_o=0, out_data_o=RST_VAL, in_ready_o=1 immediately; no stale word appears after release.
- Parameter sweep:
  - Stimulus: DATA_W=16, N_SRC=4, SEL_W=2; random valid/ready traffic over 1000 cycles.
  - Required: the scoreboard matches order and data exactly, and sel_err_o is never set.
